// File: rtl/irq_pending_dispatcher.sv
// Purpose: latches 8 interrupt request lines into a pending register and applies the mask. It sends the masked
//          vector to an external 8-to-3 priority encoder. The winning ID comes back and is offered on a valid/ready handshake.
// Latency: irq_in rise sampled at edge k -> pend_vec after k -> irq_valid after k+1; one idle cycle between offers.
// Backpressure: an offer is held (ID frozen, no retraction) until irq_ready; requests keep accumulating in pending.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   irq_in[7:0]              raw requests (synchronous to clk)
//   irq_mask[7:0]            1 = request line enabled
//   pend_vec[7:0]            pending & mask, combinational, drives encoder data_in
//   enc_id[2:0], enc_valid   encoder result
//   irq_valid, irq_id[2:0]   registered offer
//   irq_ready                consumer accepts the offer
//   pending_out[7:0]         raw pending register
//   overflow, ovf_clear      sticky "request hit an already-pending bit" flag and its clear
module irq_pending_dispatcher #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] irq_mask,
  output logic [7:0] pend_vec,
  input  logic [2:0] enc_id,
  input  logic       enc_valid,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ready,
  output logic [7:0] pending_out,
  output logic       overflow,
  input  logic       ovf_clear
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] irq_prev_q, irq_prev_d;
  logic       irq_valid_q, irq_valid_d;
  logic [2:0] irq_id_q, irq_id_d;
  logic       overflow_q, overflow_d;

  logic [7:0] set_vec;
  logic [7:0] clr_vec;

  // Pending register, edge detect and overflow tracking.
  always_comb begin
    irq_prev_d = irq_in;
    if (EDGE_MODE) begin
      set_vec = irq_in & ~irq_prev_q;
    end else begin
      set_vec = irq_in;
    end

    clr_vec = 8'd0;
    if (irq_valid_q && irq_ready) begin
      clr_vec = 8'd1 << irq_id_q;
    end

    // A new request on the bit being acked in the same cycle keeps it pending.
    pending_d = set_vec | (pending_q & ~clr_vec);

    // Only a request landing on a bit that stays pending is lost; a new
    // overflow beats a simultaneous clear so no event goes unreported.
    overflow_d = overflow_q;
    if (ovf_clear) begin
      overflow_d = 1'b0;
    end
    if (EDGE_MODE && (|(set_vec & pending_q & ~clr_vec))) begin
      overflow_d = 1'b1;
    end
  end

  // Offer FSM: the ID is captured once and held until accepted.
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    unique case (state_q)
      IDLE: begin
        irq_valid_d = 1'b0;
        if (enc_valid) begin
          irq_id_d    = enc_id;
          irq_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        irq_valid_d = 1'b1;
        if (irq_ready) begin
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        irq_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= 8'd0;
      irq_prev_q  <= 8'd0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 3'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      irq_prev_q  <= irq_prev_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      overflow_q  <= overflow_d;
    end
  end

  assign pend_vec    = pending_q & irq_mask;
  assign pending_out = pending_q;
  assign irq_valid   = irq_valid_q;
  assign irq_id      = irq_id_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_irq_pending_dispatcher.sv
module tb_irq_pending_dispatcher;

  logic       clk;
  logic       rst;

  // Edge-mode DUT
  logic [7:0] irq_in, irq_mask, pend_vec, pending_out;
  logic [2:0] enc_id, irq_id;
  logic       enc_valid, irq_valid, irq_ready, overflow, ovf_clear;

  // Level-mode DUT
  logic [7:0] l_irq_in, l_irq_mask, l_pend_vec, l_pending_out;
  logic [2:0] l_enc_id, l_irq_id;
  logic       l_enc_valid, l_irq_valid, l_irq_ready, l_overflow, l_ovf_clear;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  irq_pending_dispatcher #(.EDGE_MODE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .pend_vec(pend_vec),
    .enc_id(enc_id), .enc_valid(enc_valid), .irq_valid(irq_valid), .irq_id(irq_id),
    .irq_ready(irq_ready), .pending_out(pending_out), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  irq_pending_dispatcher #(.EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .rst(rst), .irq_in(l_irq_in), .irq_mask(l_irq_mask), .pend_vec(l_pend_vec),
    .enc_id(l_enc_id), .enc_valid(l_enc_valid), .irq_valid(l_irq_valid), .irq_id(l_irq_id),
    .irq_ready(l_irq_ready), .pending_out(l_pending_out), .overflow(l_overflow),
    .ovf_clear(l_ovf_clear)
  );

  // Reference 8-to-3 priority encoder: highest set bit wins.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    enc_id      = prio_enc(pend_vec);
    enc_valid   = |pend_vec;
    l_enc_id    = prio_enc(l_pend_vec);
    l_enc_valid = |l_pend_vec;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and registered outputs are checked 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every accepted handshake must match the next expected ID.
  always @(negedge clk) begin
    if (!rst && irq_valid && irq_ready) begin
      chk("sb_has_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) chk("sb_id", 8'(irq_id), 8'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1;
    irq_in = 8'h00; irq_mask = 8'hFF; irq_ready = 1'b0; ovf_clear = 1'b0;
    l_irq_in = 8'h00; l_irq_mask = 8'hFF; l_irq_ready = 1'b0; l_ovf_clear = 1'b0;

    // 1: reset and idle
    repeat (3) step();
    chk("rst_valid", 8'(irq_valid), 8'd0);
    chk("rst_pending", pending_out, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_pend_vec", pend_vec, 8'h00);
      chk("idle_valid", 8'(irq_valid), 8'd0);
      chk("idle_id", 8'(irq_id), 8'd0);
      chk("idle_ovf", 8'(overflow), 8'd0);
    end

    // 2: single pulse on bit 3, held offer, then accept
    irq_in = 8'h08; exp_q.push_back(3'd3);
    step();
    irq_in = 8'h00;
    chk("t2_pend_vec", pend_vec, 8'h08);
    chk("t2_valid_early", 8'(irq_valid), 8'd0);
    step();
    chk("t2_valid", 8'(irq_valid), 8'd1);
    chk("t2_id", 8'(irq_id), 8'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", 8'(irq_valid), 8'd1);
      chk("t2_hold_id", 8'(irq_id), 8'd3);
    end
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    chk("t2_cleared", pending_out, 8'h00);
    chk("t2_valid_drop", 8'(irq_valid), 8'd0);

    // 3: simultaneous edges on 0,5,7 served highest first with a bubble between
    irq_ready = 1'b1;
    irq_in = 8'hA1;
    exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd0);
    step();
    irq_in = 8'h00;
    chk("t3_pending", pending_out, 8'hA1);
    step(); chk("t3_id7", {irq_valid, 4'd0, irq_id}, 8'h87);
    step(); chk("t3_bubble1", 8'(irq_valid), 8'd0);
    step(); chk("t3_id5", {irq_valid, 4'd0, irq_id}, 8'h85);
    step(); chk("t3_bubble2", 8'(irq_valid), 8'd0);
    step(); chk("t3_id0", {irq_valid, 4'd0, irq_id}, 8'h80);
    step();
    chk("t3_end_valid", 8'(irq_valid), 8'd0);
    chk("t3_end_pending", pending_out, 8'h00);

    // 4: masked bit stays pending and is served once unmasked
    irq_mask = 8'h7F;
    irq_in = 8'h84; exp_q.push_back(3'd2);
    step();
    irq_in = 8'h00;
    chk("t4_pend_vec", pend_vec, 8'h04);
    chk("t4_pending", pending_out, 8'h84);
    step(); chk("t4_id2", {irq_valid, 4'd0, irq_id}, 8'h82);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_offer", 8'(irq_valid), 8'd0);
      chk("t4_masked_kept", pending_out, 8'h80);
      step();
    end
    irq_mask = 8'hFF; exp_q.push_back(3'd7);
    step(); chk("t4_id7", {irq_valid, 4'd0, irq_id}, 8'h87);
    step(); chk("t4_end_pending", pending_out, 8'h00);
    irq_ready = 1'b0;

    // 5: repeated edge on a pending bit sets overflow, even against ovf_clear
    irq_in = 8'h10; exp_q.push_back(3'd4);
    step();
    irq_in = 8'h00;
    step(); chk("t5_id4", {irq_valid, 4'd0, irq_id}, 8'h84);
    irq_in = 8'h10; ovf_clear = 1'b1;
    step();
    irq_in = 8'h00; ovf_clear = 1'b0;
    chk("t5_ovf_set_wins", 8'(overflow), 8'd1);
    chk("t5_pending", pending_out, 8'h10);
    irq_ready = 1'b1;
    step();
    chk("t5_acked", pending_out, 8'h00);
    step();
    chk("t5_single_offer", 8'(irq_valid), 8'd0);
    chk("t5_ovf_sticky", 8'(overflow), 8'd1);
    irq_ready = 1'b0; ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("t5_ovf_cleared", 8'(overflow), 8'd0);

    // 5b: new edge on the bit being acked keeps it pending, no overflow
    irq_in = 8'h10; exp_q.push_back(3'd4);
    step();
    irq_in = 8'h00;
    step(); chk("t5b_id4", {irq_valid, 4'd0, irq_id}, 8'h84);
    irq_in = 8'h10; irq_ready = 1'b1; exp_q.push_back(3'd4);
    step();
    irq_in = 8'h00;
    chk("t5b_set_wins", pending_out, 8'h10);
    chk("t5b_no_ovf", 8'(overflow), 8'd0);
    step(); chk("t5b_reoffer", {irq_valid, 4'd0, irq_id}, 8'h84);
    step(); chk("t5b_end_pending", pending_out, 8'h00);
    irq_ready = 1'b0;

    // 6: asynchronous reset during an offer drops everything
    irq_in = 8'hA5;
    step();
    irq_in = 8'h00;
    step();
    irq_in = 8'h80;
    step();
    irq_in = 8'h00;
    chk("t6_pre_state", {irq_valid, overflow, 3'd0, irq_id}, 8'hC7);
    chk("t6_pre_pending", pending_out, 8'hA5);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_valid", 8'(irq_valid), 8'd0);
    chk("t6_async_pending", pending_out, 8'h00);
    chk("t6_async_ovf", 8'(overflow), 8'd0);
    chk("t6_async_id", 8'(irq_id), 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_stale", {irq_valid, pending_out[6:0]}, 8'h00);
    end

    // Level mode: held request re-pends after each ack, never overflows
    l_irq_in = 8'h02; l_irq_ready = 1'b1;
    step(); chk("lv_pending", l_pending_out, 8'h02);
    step(); chk("lv_offer1", {l_irq_valid, 4'd0, l_irq_id}, 8'h81);
    step();
    chk("lv_repend", l_pending_out, 8'h02);
    chk("lv_bubble", 8'(l_irq_valid), 8'd0);
    step();
    l_irq_in = 8'h00;
    chk("lv_offer2", {l_irq_valid, 4'd0, l_irq_id}, 8'h81);
    step();
    chk("lv_cleared", l_pending_out, 8'h00);
    chk("lv_no_ovf", 8'(l_overflow), 8'd0);

    chk("sb_drain", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
